// File: rtl/serial_sub_pkg.sv
`default_nettype none
// =============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and defaults for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// =============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// =============================================================================
// Module      : full_subtractor
// Description : Gate-level one-bit full subtractor (a - b - borrow_in).
// Revision    : 1.0 - initial release
// =============================================================================
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow_in,
    output logic o_d,
    output logic o_borrow_out
);

    logic w_axb;

    assign w_axb        = i_a ^ i_b;
    assign o_d          = w_axb ^ i_borrow_in;
    assign o_borrow_out = (~i_a & i_b) | (~w_axb & i_borrow_in);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, one full-subtractor cell.
// Revision    : 1.0 - initial release
// =============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow
);

    localparam int unsigned C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [WIDTH-1:0]     diff_q, diff_d;
    logic                 borrow_q, borrow_d;
    logic                 ovf_q, ovf_d;

    logic                 w_d;
    logic                 w_bout;

    full_subtractor u_cell (
        .i_a          (a_sh_q[0]),
        .i_b          (b_sh_q[0]),
        .i_borrow_in  (borrow_q),
        .o_d          (w_d),
        .o_borrow_out (w_bout)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_sh_d   = i_a;
                    b_sh_d   = i_b;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                diff_d   = {w_d, diff_q[WIDTH-1:1]};
                borrow_d = w_bout;
                cnt_d    = cnt_q + C_CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    // Signed overflow: borrow into MSB differs from borrow out.
                    ovf_d   = borrow_q ^ w_bout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_diff     = diff_q;
    assign o_borrow   = borrow_q;
    assign o_overflow = ovf_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module      : tb_serial_subtractor
// Description : Directed vector bench for serial_subtractor (WIDTH = 8).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs [7];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_ready     (ready),
        .i_a         (a),
        .i_b         (b),
        .o_valid     (valid),
        .i_res_ready (res_ready),
        .o_diff      (diff),
        .o_borrow    (borrow),
        .o_overflow  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, wait for the result, check it, then consume it.
    task automatic do_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
        int cyc;
        chk({name, "_ready"}, 32'(ready), 32'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = 8'hXX;
        b     = 8'hXX;
        cyc   = 0;
        while (!valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(WIDTH));
        chk({name, "_diff"},    32'(diff),   32'(ed));
        chk({name, "_borrow"},  32'(borrow), 32'(eb));
        chk({name, "_ovf"},     32'(ovf),    32'(eo));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, "_ready_after"}, 32'(ready), 32'd1);
        chk({name, "_valid_after"}, 32'(valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{8'd100, 8'd58, 8'h2A, 1'b0, 1'b0};
        vecs[1] = '{8'h00,  8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hA5,  8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80,  8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h01,  8'h80, 8'h81, 1'b1, 1'b1};
        vecs[6] = '{8'hC8,  8'h32, 8'h96, 1'b0, 1'b0};

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready",  32'(ready),  32'd1);
        chk("rst_valid",  32'(valid),  32'd0);
        chk("rst_diff",   32'(diff),   32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf",    32'(ovf),    32'd0);
        tick();

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
        end

        // Backpressure with ignored start pulses
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30 && !valid; k++) tick();
        chk("bp_valid", 32'(valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'h00;
            tick();
            chk("bp_hold_valid", 32'(valid), 32'd1);
            chk("bp_hold_ready", 32'(ready), 32'd0);
            chk("bp_hold_diff",  32'(diff),  32'h22);
            chk("bp_hold_borrow", 32'(borrow), 32'd0);
            chk("bp_hold_ovf",   32'(ovf),   32'd0);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_ready_after", 32'(ready), 32'd1);
        chk("bp_valid_after", 32'(valid), 32'd0);
        do_op("bp_next", 8'h10, 8'h03, 8'h0D, 1'b0, 1'b0);

        // Reset on the third shift cycle
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h22;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ready",  32'(ready),  32'd1);
        chk("mid_rst_valid",  32'(valid),  32'd0);
        chk("mid_rst_diff",   32'(diff),   32'd0);
        chk("mid_rst_borrow", 32'(borrow), 32'd0);
        chk("mid_rst_ovf",    32'(ovf),    32'd0);
        tick();
        do_op("post_rst", 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
